bcd_to_binary_seq: RTL

- Sequential 3-digit BCD to 8-bit binary converter; the reverse of the display path's binary-to-BCD conversion.
- Used where keypad/switch BCD entries must be turned back into binary operands for the arithmetic datapath.
- Uses a reverse double-dabble algorithm: shift right one bit per clock, then subtract 3 from any digit that is ≥8.
- Start/busy/done handshake; flags invalid digits and results above 255.

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bcd_sub3.sv | 9 +
 rtl/bcd_to_binary_seq.sv | 121 ++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and digit-validity helper for the BCD converters.
package bcd_pkg;
  localparam int BCD_DIG_W   = 4;
  localparam int BCD_BIN_W   = 8;
  localparam int BCD_ITERS   = 8;
  localparam int BCD_MAX_VAL = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_t;

  function automatic logic bcd_digit_invalid(input logic [BCD_DIG_W-1:0] d);
    return d > 4'd9;
  endfunction
endpackage

// File: rtl/bcd_sub3.sv
// Reverse double-dabble correction cell: subtract 3 from a BCD field that reached 8 or more.
module bcd_sub3
  import bcd_pkg::*;
(
  input  logic [BCD_DIG_W-1:0] d_i,
  output logic [BCD_DIG_W-1:0] d_o
);
  assign d_o = (d_i >= 4'd8) ? (d_i - 4'd3) : d_i;
endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential 3-digit BCD to binary converter (reverse double-dabble, one bit per clock).
// Define BCD_TO_BINARY_SAT_EN to saturate the result to 8'hFF when ovf is set.
module bcd_to_binary_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W = 8,
  parameter int DIG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       hundreds,
  input  logic [3:0]       tens,
  input  logic [3:0]       units,
  output logic             busy,
  output logic             done,
  output logic [BIN_W-1:0] binary,
  output logic             ovf,
  output logic             err
);
  generate
    if (BIN_W != BCD_BIN_W || DIG_W != BCD_DIG_W) begin : g_bad_cfg
      $error("bcd_to_binary_seq supports only BIN_W=8, DIG_W=4");
    end
  endgenerate

  localparam logic [2:0] ITER_LAST = 3'(BCD_ITERS - 1);

  bcd_state_t  state_q, state_d;
  logic [17:0] work_q, work_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  bin_q, bin_d;
  logic        ovf_q, ovf_d;
  logic        err_q, err_d;
  logic        done_q, done_d;

  // Shift first, then correct each digit field of the shifted register.
  logic [17:0] shifted, stepped;
  logic [3:0]  hun_adj, tens_adj, units_adj;
  logic        unused_hun_hi;

  assign shifted = {1'b0, work_q[17:1]};

  bcd_sub3 u_sub_hun   (.d_i({2'b00, shifted[17:16]}), .d_o(hun_adj));
  bcd_sub3 u_sub_tens  (.d_i(shifted[15:12]),          .d_o(tens_adj));
  bcd_sub3 u_sub_units (.d_i(shifted[11:8]),           .d_o(units_adj));

  // Zero-extended hundreds can never reach 8, so its upper bits stay zero.
  assign unused_hun_hi = ^hun_adj[3:2];
  assign stepped       = {hun_adj[1:0], tens_adj, units_adj, shifted[7:0]};

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d = {hundreds, tens, units, 8'b0};
          bin_d  = '0;
          cnt_d  = '0;
          if (bcd_digit_invalid(tens) || bcd_digit_invalid(units)) begin
            err_d   = 1'b1;
            ovf_d   = 1'b0;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            ovf_d   = (hundreds == 2'd3) ||
                      ((hundreds == 2'd2) && ({tens, units} > 8'h55));
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_d = stepped;
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == ITER_LAST) state_d = DONE;
      end
      DONE: begin
        done_d = 1'b1;
`ifdef BCD_TO_BINARY_SAT_EN
        bin_d  = ovf_q ? 8'hFF : work_q[7:0];
`else
        bin_d  = work_q[7:0];
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign busy   = (state_q == SHIFT);
  assign done   = done_q;
  assign binary = bin_q;
  assign ovf    = ovf_q;
  assign err    = err_q;
endmodule
